// File: rtl/pool_readout_ctrl_pkg.sv
// Shared definitions for the pooled-activation readout path: default geometry,
// pooling-mode encodings, readout FSM states and the drain word-count helper.
package sys_defs;

    localparam int unsigned OUTPUT_HEIGHT   = 4;
    localparam int unsigned OUTPUT_WIDTH    = 8;
    localparam int unsigned OUTPUT_SRAM_LEN = 4;
    localparam int unsigned DEF_BIN_LEN     = 8;
    localparam int unsigned DEF_ADDR_W      = 16;

    localparam logic [1:0] POOL_NONE = 2'd0;
    localparam logic [1:0] POOL_MAX  = 2'd1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LATCH = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } pool_rd_state_t;

    // Number of SRAM words needed to drain an h x w array, len elements per word.
    function automatic int unsigned pool_word_count(input int unsigned h,
                                                    input int unsigned w,
                                                    input int unsigned len);
        return (h * w) / len;
    endfunction

endpackage

// File: rtl/pool_readout_ctrl.sv
// Drains the pooled activation array into the output SRAM: one read, one capture
// and one valid/ready write per (row, column-group), at consecutive addresses.
module pool_readout_ctrl
    import sys_defs::*;
#(
    parameter int unsigned OUT_H    = OUTPUT_HEIGHT,
    parameter int unsigned OUT_W    = OUTPUT_WIDTH,
    parameter int unsigned SRAM_LEN = OUTPUT_SRAM_LEN,
    parameter int unsigned BIN_LEN  = DEF_BIN_LEN,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    localparam int unsigned RW = (OUT_H > 1) ? $clog2(OUT_H) : 1,
    localparam int unsigned CW = (OUT_W > 1) ? $clog2(OUT_W) : 1,
    localparam int unsigned DW = BIN_LEN * SRAM_LEN
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              start_i,
    input  logic [1:0]        cfg_pool_type_i,
    input  logic [2:0]        cfg_pool_stride_i,
    input  logic [2:0]        cfg_pool_kernel_i,
    input  logic [ADDR_W-1:0] cfg_base_addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        pool_type_o,
    output logic [2:0]        pool_stride_o,
    output logic [2:0]        pool_kernel_o,
    output logic              pa_r_en_o,
    output logic [RW-1:0]     pa_r_o,
    output logic [CW-1:0]     pa_c_o,
    input  logic [DW-1:0]     pa_data_i,
    output logic              wr_valid_o,
    input  logic              wr_ready_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DW-1:0]     wr_data_o
);

    localparam logic [RW-1:0] LAST_ROW = RW'(OUT_H - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(OUT_W - SRAM_LEN);
    localparam logic [CW-1:0] COL_STEP = CW'(SRAM_LEN);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    pool_rd_state_t    state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DW-1:0]     data_q, data_d;
    logic [1:0]        type_q, type_d;
    logic [2:0]        stride_q, stride_d;
    logic [2:0]        kernel_q, kernel_d;

    logic last_col;
    logic last_word;

    assign last_col  = (col_q == LAST_COL);
    assign last_word = last_col && (row_q == LAST_ROW);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            type_q   <= '0;
            stride_q <= '0;
            kernel_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            type_q   <= type_d;
            stride_q <= stride_d;
            kernel_q <= kernel_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        addr_d     = addr_q;
        data_d     = data_q;
        type_d     = type_q;
        stride_d   = stride_q;
        kernel_d   = kernel_q;
        pa_r_en_o  = 1'b0;
        wr_valid_o = 1'b0;
        done_o     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    type_d   = cfg_pool_type_i;
                    stride_d = cfg_pool_stride_i;
                    kernel_d = cfg_pool_kernel_i;
                    addr_d   = cfg_base_addr_i;
                    row_d    = '0;
                    col_d    = '0;
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                pa_r_en_o = 1'b1;
                state_d   = ST_LATCH;
            end
            // Pool array data is registered, so it is valid in the cycle after the read.
            ST_LATCH: begin
                data_d  = pa_data_i;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                wr_valid_o = 1'b1;
                if (wr_ready_i) begin
                    addr_d = addr_q + ADDR_ONE;
                    if (last_word) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                        if (last_col) begin
                            col_d = '0;
                            row_d = row_q + ROW_ONE;
                        end else begin
                            col_d = col_q + COL_STEP;
                        end
                    end
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign pool_type_o   = type_q;
    assign pool_stride_o = stride_q;
    assign pool_kernel_o = kernel_q;
    assign pa_r_o        = row_q;
    assign pa_c_o        = col_q;
    assign wr_addr_o     = addr_q;
    assign wr_data_o     = data_q;

endmodule

// File: tb/tb_pool_readout_ctrl.sv
// Scoreboard bench for pool_readout_ctrl: a memory model of the pool array answers
// reads, expected writes are queued per drain and a monitor pops them on each handshake.
module tb_pool_readout_ctrl;
    import sys_defs::*;

    localparam int H  = 4;
    localparam int W  = 8;
    localparam int L  = 4;
    localparam int B  = 8;
    localparam int G  = W / L;
    localparam int DW = B * L;
    localparam int WORDS = int'(pool_word_count(H, W, L));

    typedef struct packed {
        logic [15:0]   addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    cfg_type = '0;
    logic [2:0]    cfg_stride = '0;
    logic [2:0]    cfg_kernel = '0;
    logic [15:0]   cfg_base = '0;
    logic          busy, done;
    logic [1:0]    pool_type;
    logic [2:0]    pool_stride, pool_kernel;
    logic          pa_r_en;
    logic [1:0]    pa_r;
    logic [2:0]    pa_c;
    logic [DW-1:0] pa_data = '0;
    logic          wr_valid;
    logic          wr_ready = 1'b1;
    logic [15:0]   wr_addr;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] pa_mem [H][G];
    wr_t           sb_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            drain_acc = 0;
    int            rdy_mode = 0;
    int            stall_word = 0;
    int            stall_left = 0;

    pool_readout_ctrl #(.OUT_H(H), .OUT_W(W), .SRAM_LEN(L), .BIN_LEN(B), .ADDR_W(16)) dut (
        .clock(clock), .reset(reset), .start_i(start),
        .cfg_pool_type_i(cfg_type), .cfg_pool_stride_i(cfg_stride),
        .cfg_pool_kernel_i(cfg_kernel), .cfg_base_addr_i(cfg_base),
        .busy_o(busy), .done_o(done),
        .pool_type_o(pool_type), .pool_stride_o(pool_stride), .pool_kernel_o(pool_kernel),
        .pa_r_en_o(pa_r_en), .pa_r_o(pa_r), .pa_c_o(pa_c), .pa_data_i(pa_data),
        .wr_valid_o(wr_valid), .wr_ready_i(wr_ready),
        .wr_addr_o(wr_addr), .wr_data_o(wr_data)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pool array model: registered read, junk when not reading.
    always @(posedge clock) begin
        if (pa_r_en)
            pa_data <= pa_mem[int'(pa_r)][int'(pa_c) / L];
        else
            pa_data <= $urandom;
    end

    // Output SRAM ready driver.
    initial forever begin
        @(posedge clock);
        #1;
        case (rdy_mode)
            1: wr_ready = 1'($urandom_range(0, 1));
            2: begin
                if (wr_valid && drain_acc == stall_word && stall_left > 0) begin
                    wr_ready = 1'b0;
                    stall_left--;
                end else begin
                    wr_ready = 1'b1;
                end
            end
            default: wr_ready = 1'b1;
        endcase
    end

    // Monitor: pops the scoreboard on every handshake, checks stability while stalled.
    initial forever begin
        wr_t e;
        @(negedge clock);
        if (pa_r_en) check("pa_c_align", 64'(int'(pa_c) % L), 64'd0);
        if (wr_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", 64'(wr_addr), 64'hDEAD_0000_0000);
            end else begin
                e = sb_q[0];
                if (wr_ready) begin
                    void'(sb_q.pop_front());
                    check("wr_addr", 64'(wr_addr), 64'(e.addr));
                    check("wr_data", 64'(wr_data), 64'(e.data));
                    $display("write addr=0x%04h data=0x%08h", wr_addr, wr_data);
                    drain_acc++;
                end else begin
                    check("stall_addr", 64'(wr_addr), 64'(e.addr));
                    check("stall_data", 64'(wr_data), 64'(e.data));
                    check("stall_pa_r_en", 64'(pa_r_en), 64'd0);
                end
            end
        end
    end

    task automatic fill_pattern();
        for (int r = 0; r < H; r++)
            for (int g = 0; g < G; g++)
                pa_mem[r][g] = {16'(r), 16'(g * L)};
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int g = 0; g < G; g++)
                pa_mem[r][g] = $urandom;
    endtask

    task automatic push_expected(input logic [15:0] base);
        wr_t e;
        for (int k = 0; k < WORDS; k++) begin
            e.addr = base + 16'(k);
            e.data = pa_mem[k / G][k % G];
            sb_q.push_back(e);
        end
        drain_acc = 0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_pa_r_en"}, 64'(pa_r_en), 64'd0);
        check({tag, "_wr_valid"}, 64'(wr_valid), 64'd0);
        check({tag, "_cfg"}, 64'({pool_type, pool_stride, pool_kernel}), 64'd0);
        check({tag, "_rc"}, 64'({pa_r, pa_c}), 64'd0);
        check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    endtask

    // One full drain; exp_done < 0 skips the done-cycle check.
    task automatic run_drain(input logic [15:0] base, input logic [1:0] pt, input logic [2:0] ps,
                             input logic [2:0] pk, input int exp_done, input bit mid_start);
        int  n;
        bit  seen;
        check("idle_before_start", 64'(busy), 64'd0);
        push_expected(base);
        cfg_type = pt; cfg_stride = ps; cfg_kernel = pk; cfg_base = base;
        start = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            @(posedge clock);
            n++;
            #1;
            start = 1'b0;
            if (mid_start && n == 10) begin
                start = 1'b1;
                cfg_type = ~pt; cfg_stride = ~ps; cfg_kernel = ~pk; cfg_base = ~base;
            end
            @(negedge clock);
            check("busy", 64'(busy), 64'd1);
            check("cfg_latched", 64'({pool_type, pool_stride, pool_kernel}), 64'({pt, ps, pk}));
            if (done) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'd1);
        if (exp_done >= 0) check("done_cycle", 64'(n), 64'(exp_done));
        @(negedge clock);
        check("idle_after_done", 64'({busy, done}), 64'd0);
        check("words_accepted", 64'(drain_acc), 64'(WORDS));
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    task automatic run_reset_abort(input logic [15:0] base);
        int n;
        push_expected(base);
        rdy_mode = 2; stall_word = 5; stall_left = 1000;
        cfg_type = POOL_MAX; cfg_stride = 3'd3; cfg_kernel = 3'd3; cfg_base = base;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(wr_valid && !wr_ready && drain_acc == 5) && n < 200);
        check("reach_word5", 64'(n < 200), 64'd1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        rdy_mode = 0; stall_left = 0;
        @(negedge clock);
        check_idle_zero("abort");
        check("abort_accepted", 64'(drain_acc), 64'd5);
        sb_q.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check("no_done_after_abort", 64'({done, busy, wr_valid}), 64'd0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_idle_zero("reset");

        fill_pattern();
        rdy_mode = 0;
        run_drain(16'h0010, POOL_MAX, 3'd2, 3'd2, 25, 1'b0);

        rdy_mode = 2; stall_word = 3; stall_left = 5;
        run_drain(16'h0020, POOL_MAX, 3'd1, 3'd2, 30, 1'b0);

        rdy_mode = 1;
        run_drain(16'h0030, POOL_NONE, 3'd2, 3'd3, -1, 1'b0);

        rdy_mode = 0;
        run_drain(16'h0040, POOL_NONE, 3'd1, 3'd3, 25, 1'b1);

        fill_random();
        run_reset_abort(16'h0100);
        run_drain(16'h0200, POOL_MAX, 3'd2, 3'd3, 25, 1'b0);

        fill_random();
        run_drain(16'hFFFE, POOL_MAX, 3'd4, 3'd5, 25, 1'b0);

        for (int t = 0; t < 3; t++) begin
            fill_random();
            rdy_mode = 1;
            run_drain(16'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), -1, 1'b0);
        end
        rdy_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
